// File: rtl/wallace_pkg.sv
// Shared constants and tree-sizing helpers for the pipelined Wallace-tree multiplier.
package wallace_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int PROD_W    = 2 * DEF_WIDTH;
    localparam int LAT       = 3;

    // Rows remaining after k levels of 3:2 compression; leftovers pass through a level.
    function automatic int rows_after(input int n, input int k);
        int r;
        r = n;
        for (int i = 0; (i < k) && (r > 2); i++) begin
            r = 2 * (r / 3) + (r % 3);
        end
        return r;
    endfunction

    function automatic int csa_levels(input int n);
        int r;
        int c;
        r = n;
        c = 0;
        while (r > 2) begin
            r = 2 * (r / 3) + (r % 3);
            c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/csa_row.sv
// W-bit 3:2 carry-save compressor; the carry row is pre-shifted by one with its MSB dropped.
module csa_row #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum   = x ^ y ^ z;
    assign carry = {(x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]), 1'b0};

endmodule

// File: rtl/wallace_mult_pipe.sv
// Three-stage pipelined Wallace-tree multiplier, unsigned or signed per operation,
// with valid/ready flow control at both ends and a tag carried alongside each operation.
module wallace_mult_pipe
    import wallace_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int PW    = 2 * WIDTH;
    localparam int LVLS  = csa_levels(WIDTH);
    localparam int HALF  = (LVLS + 1) / 2;
    localparam int MID_N = rows_after(WIDTH, HALF);
    localparam logic [PW-1:0] ONE = {{(PW-1){1'b0}}, 1'b1};

    logic               v0_r, v1_r, v2_r;
    logic               en0_s, en1_s, en2_s;
    logic [WIDTH-1:0]   a0_r, b0_r;
    logic               sign0_r;
    logic [TAG_W-1:0]   tag0_r, tag1_r, tag2_r;
    logic [PW-1:0]      mid_r [MID_N];
    logic [PW-1:0]      prod_r;
    logic [PW-1:0]      a_ext_s;
    logic [PW-1:0]      pp_s [WIDTH];
    logic [PW-1:0]      sum_s;

    // Each stage advances when it is empty or its successor advances.
    always_comb begin
        en2_s = !v2_r || out_ready;
        en1_s = !v1_r || en2_s;
        en0_s = !v0_r || en1_s;
    end

    assign in_ready = en0_s;

    assign a_ext_s = sign0_r ? {{WIDTH{a0_r[WIDTH-1]}}, a0_r} : {{WIDTH{1'b0}}, a0_r};

    // Partial products; in signed mode the top multiplier bit carries negative weight.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            if (!b0_r[i]) begin
                pp_s[i] = '0;
            end else if (sign0_r && (i == WIDTH - 1)) begin
                pp_s[i] = (~(a_ext_s << i)) + ONE;
            end else begin
                pp_s[i] = a_ext_s << i;
            end
        end
    end

    // Level l compresses the rows of level l-1; the first level after HALF reads the S1 register.
    for (genvar l = 1; l <= LVLS; l++) begin : g_lvl
        localparam int NI  = rows_after(WIDTH, l - 1);
        localparam int NO  = rows_after(WIDTH, l);
        localparam int GRP = NI / 3;

        logic [PW-1:0] src [NI];
        logic [PW-1:0] r   [NO];

        for (genvar k = 0; k < NI; k++) begin : g_src
            if (l == 1) begin : g_pp
                assign src[k] = pp_s[k];
            end else if (l == HALF + 1) begin : g_reg
                assign src[k] = mid_r[k];
            end else begin : g_prev
                assign src[k] = g_lvl[l-1].r[k];
            end
        end

        for (genvar j = 0; j < GRP; j++) begin : g_csa
            csa_row #(.W(PW)) u_csa (
                .x     (src[3*j]),
                .y     (src[3*j+1]),
                .z     (src[3*j+2]),
                .sum   (r[2*j]),
                .carry (r[2*j+1])
            );
        end

        for (genvar k = 0; k < NI - 3 * GRP; k++) begin : g_pass
            assign r[2*GRP+k] = src[3*GRP+k];
        end
    end

    assign sum_s = g_lvl[LVLS].r[0] + g_lvl[LVLS].r[1];

    // Pipeline registers; a stalled stage keeps both its data and its valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_r    <= 1'b0;
            v1_r    <= 1'b0;
            v2_r    <= 1'b0;
            a0_r    <= '0;
            b0_r    <= '0;
            sign0_r <= 1'b0;
            tag0_r  <= '0;
            tag1_r  <= '0;
            tag2_r  <= '0;
            prod_r  <= '0;
            for (int k = 0; k < MID_N; k++) begin
                mid_r[k] <= '0;
            end
        end else begin
            if (en0_s) begin
                v0_r    <= in_valid;
                a0_r    <= in_a;
                b0_r    <= in_b;
                sign0_r <= in_signed;
                tag0_r  <= in_tag;
            end
            if (en1_s) begin
                v1_r   <= v0_r;
                tag1_r <= tag0_r;
                for (int k = 0; k < MID_N; k++) begin
                    mid_r[k] <= g_lvl[HALF].r[k];
                end
            end
            if (en2_s) begin
                v2_r   <= v1_r;
                tag2_r <= tag1_r;
                prod_r <= sum_s;
            end
        end
    end

    assign out_valid = v2_r;
    assign out_prod  = prod_r;
    assign out_tag   = tag2_r;

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Bench for wallace_mult_pipe: directed products, streaming, back-pressure, mid-stream reset
// and a width sweep, all scored against a plain-arithmetic multiply model.
module tb_wallace_mult_pipe;
    import wallace_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   n_stall = 0;

    // Main 16-bit instance.
    logic              in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [15:0]       in_a, in_b;
    logic [3:0]        in_tag, out_tag;
    logic [PROD_W-1:0] out_prod;

    // Width-sweep instances share one valid strobe and one tag.
    logic        sw_valid, rdy4, rdy8, rdy32, ov4, ov8, ov32;
    logic [3:0]  a4, b4, tsw, ot4, ot8, ot32;
    logic [7:0]  a8, b8, op4;
    logic [31:0] a32, b32;
    logic [15:0] op8;
    logic [63:0] op32;
    logic        s4, s8, s32;

    logic [35:0] mq [$];
    logic [67:0] q4 [$], q8 [$], q32 [$];

    wallace_mult_pipe #(.WIDTH(16), .TAG_W(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_signed(in_signed), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_prod(out_prod), .out_tag(out_tag));

    wallace_mult_pipe #(.WIDTH(4), .TAG_W(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy4), .in_a(a4), .in_b(b4),
        .in_signed(s4), .in_tag(tsw), .out_valid(ov4), .out_ready(1'b1), .out_prod(op4), .out_tag(ot4));

    wallace_mult_pipe #(.WIDTH(8), .TAG_W(4)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy8), .in_a(a8), .in_b(b8),
        .in_signed(s8), .in_tag(tsw), .out_valid(ov8), .out_ready(1'b1), .out_prod(op8), .out_tag(ot8));

    wallace_mult_pipe #(.WIDTH(32), .TAG_W(4)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy32), .in_a(a32), .in_b(b32),
        .in_signed(s32), .in_tag(tsw), .out_valid(ov32), .out_ready(1'b1), .out_prod(op32), .out_tag(ot32));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Exact product of w-bit operands, reduced mod 2^(2w).
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input bit sg, input int w);
        logic [63:0] x, y, mask;
        mask = (64'd1 << w) - 64'd1;
        x = {32'd0, a} & mask;
        y = {32'd0, b} & mask;
        if (sg && x[w-1]) x = x - (64'd1 << w);
        if (sg && y[w-1]) y = y - (64'd1 << w);
        if (w < 32) return (x * y) & ((64'd1 << (2 * w)) - 64'd1);
        return x * y;
    endfunction

    // Random operand biased towards min, all-ones and zero.
    function automatic logic [31:0] pick(input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 7))
            0:       return 32'd1 << (w - 1);
            1:       return m;
            2:       return 32'd0;
            default: return $urandom & m;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for the main instance: expected results queued on input transfers.
    always @(negedge clk) begin
        logic [63:0] r64;
        logic [35:0] e;
        if (rst) begin
            mq.delete();
        end else begin
            if (!in_ready) n_stall <= n_stall + 1;
            if (out_valid && out_ready) begin
                if (mq.size() == 0) begin
                    check_eq("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    e = mq.pop_front();
                    check_eq("sb_prod", 64'(out_prod), 64'(e[31:0]));
                    check_eq("sb_tag", 64'(out_tag), 64'(e[35:32]));
                    n_out <= n_out + 1;
                end
            end
            if (in_valid && in_ready) begin
                r64 = ref_mul({16'd0, in_a}, {16'd0, in_b}, in_signed, 16);
                mq.push_back({in_tag, r64[31:0]});
            end
        end
    end

    // Scoreboard for the sweep instances.
    always @(negedge clk) begin
        logic [67:0] e;
        if (rst) begin
            q4.delete(); q8.delete(); q32.delete();
        end else begin
            if (ov4) begin
                if (q4.size() == 0) check_eq("w4_spurious", 64'(ov4), 64'd0);
                else begin e = q4.pop_front(); check_eq("w4_prod", 64'(op4), e[63:0]); check_eq("w4_tag", 64'(ot4), 64'(e[67:64])); end
            end
            if (ov8) begin
                if (q8.size() == 0) check_eq("w8_spurious", 64'(ov8), 64'd0);
                else begin e = q8.pop_front(); check_eq("w8_prod", 64'(op8), e[63:0]); check_eq("w8_tag", 64'(ot8), 64'(e[67:64])); end
            end
            if (ov32) begin
                if (q32.size() == 0) check_eq("w32_spurious", 64'(ov32), 64'd0);
                else begin e = q32.pop_front(); check_eq("w32_prod", op32, e[63:0]); check_eq("w32_tag", 64'(ot32), 64'(e[67:64])); end
            end
            if (sw_valid) begin
                check_eq("sw_ready", 64'({rdy4, rdy8, rdy32}), 64'd7);
                q4.push_back({tsw, ref_mul({28'd0, a4}, {28'd0, b4}, s4, 4)});
                q8.push_back({tsw, ref_mul({24'd0, a8}, {24'd0, b8}, s8, 8)});
                q32.push_back({tsw, ref_mul(a32, b32, s32, 32)});
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sg, input logic [3:0] t);
        logic acc;
        int   n;
        in_valid = 1'b1; in_a = a; in_b = b; in_signed = sg; in_tag = t;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 64) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check_eq("send_timeout", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic sg,
                            input logic [3:0] t, input logic [31:0] exp);
        int n;
        send(a, b, sg, t);
        n = 0;
        while (!out_valid && n < LAT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("lat_valid", 64'(out_valid), 64'd1);
        check_eq("dir_prod", 64'(out_prod), 64'(exp));
        check_eq("dir_tag", 64'(out_tag), 64'(t));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          c0, o0, s0;
        logic [15:0] bpa [6];
        logic [15:0] bpb [6];
        logic        bps [6];
        logic [63:0] bp_exp;

        rst = 1'b1; out_ready = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0;
        sw_valid = 1'b0; a4 = '0; b4 = '0; a8 = '0; b8 = '0; a32 = '0; b32 = '0;
        s4 = 1'b0; s8 = 1'b0; s32 = 1'b0; tsw = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_prod", 64'(out_prod), 64'd0);
        check_eq("rst_tag", 64'(out_tag), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        directed(16'hFFFF, 16'hFFFF, 1'b0, 4'd3, 32'hFFFE_0001);
        directed(16'h8000, 16'h8000, 1'b1, 4'd5, 32'h4000_0000);
        directed(16'hFFFD, 16'h0007, 1'b1, 4'd9, 32'hFFFF_FFEB);
        directed(16'h8000, 16'h7FFF, 1'b1, 4'd1, 32'hC000_8000);
        directed(16'h8000, 16'h0002, 1'b1, 4'd2, 32'hFFFF_0000);
        directed(16'h8000, 16'h0002, 1'b0, 4'd4, 32'h0001_0000);
        directed(16'h0000, 16'hABCD, 1'b1, 4'd6, 32'h0000_0000);
        directed(16'hFFFF, 16'h0000, 1'b0, 4'd7, 32'h0000_0000);

        // Back-to-back stream with mixed modes.
        c0 = cyc; o0 = n_out; s0 = n_stall;
        for (int i = 0; i < 100; i++) begin
            send(16'(pick(16)), 16'(pick(16)), 1'($urandom_range(0, 1)), 4'($urandom));
        end
        check_eq("stream_cycles", 64'(cyc - c0), 64'd100);
        repeat (4) @(posedge clk);
        #1;
        check_eq("stream_results", 64'(n_out - o0), 64'd100);
        check_eq("stream_stalls", 64'(n_stall - s0), 64'd0);

        // Back-pressure: the oldest result must sit unchanged while the consumer stalls.
        for (int k = 0; k < 6; k++) begin
            bpa[k] = 16'(pick(16)); bpb[k] = 16'(pick(16)); bps[k] = 1'($urandom_range(0, 1));
        end
        bp_exp = ref_mul({16'd0, bpa[0]}, {16'd0, bpb[0]}, bps[0], 16);
        o0 = n_out;
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) send(bpa[k], bpb[k], bps[k], 4'(k));
            end
            begin
                repeat (4) @(negedge clk);
                for (int k = 0; k < 5; k++) begin
                    check_eq("bp_in_ready", 64'(in_ready), 64'd0);
                    check_eq("bp_valid", 64'(out_valid), 64'd1);
                    check_eq("bp_hold_prod", 64'(out_prod), bp_exp);
                    check_eq("bp_hold_tag", 64'(out_tag), 64'd0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        #1;
        check_eq("bp_results", 64'(n_out - o0), 64'd6);
        check_eq("bp_drain", 64'(mq.size()), 64'd0);

        // Reset with three operations in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(16'(pick(16)), 16'(pick(16)), 1'b1, 4'(k + 8));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_prod", 64'(out_prod), 64'd0);
        check_eq("mid_rst_tag", 64'(out_tag), 64'd0);
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("rst_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        directed(16'h1234, 16'h5678, 1'b0, 4'hA, 32'h0626_0060);

        // Width sweep: exhaustive at 4 bits, biased random at 8 and 32 bits.
        for (int i = 0; i < 512; i++) begin
            sw_valid = 1'b1;
            a4 = i[3:0]; b4 = i[7:4]; s4 = i[8]; tsw = 4'($urandom);
            a8 = 8'(pick(8)); b8 = 8'(pick(8)); s8 = 1'($urandom_range(0, 1));
            a32 = pick(32); b32 = pick(32); s32 = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        sw_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq("w4_drain", 64'(q4.size()), 64'd0);
        check_eq("w8_drain", 64'(q8.size()), 64'd0);
        check_eq("w32_drain", 64'(q32.size()), 64'd0);
        check_eq("main_drain", 64'(mq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
